// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: multiplier FSM state encoding and default operand width.
package arith_pkg;

  localparam int ARITH_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/shift_add_dp.sv
// Shift-add datapath: accumulator, left-shifting multiplicand, right-shifting multiplier.
module shift_add_dp #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 step,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   acc_nxt,
  output logic                 mplr_zero
);

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplr;

  // Sum of partial products so far; a 2*WIDTH accumulator cannot overflow.
  assign acc_nxt   = mplr[0] ? (acc + mcand) : acc;
  assign mplr_zero = (mplr == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      mcand <= '0;
      mplr  <= '0;
    end else if (load) begin
      acc   <= '0;
      mcand <= {{WIDTH{1'b0}}, a};
      mplr  <= b;
    end else if (step) begin
      acc   <= acc_nxt;
      mcand <= mcand << 1;
      mplr  <= mplr >> 1;
    end
  end

endmodule

// File: rtl/seq_multiplier.sv
// Sequential shift-add unsigned multiplier with a one-cycle done strobe.
// Optional early termination on an exhausted multiplier: define SEQ_MUL_EARLY_TERM_EN.
module seq_multiplier
  import arith_pkg::*;
#(
  parameter int WIDTH = ARITH_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [1:0]           state_dbg
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  // Handshake: start is a request honoured only in IDLE; done is a single-cycle
  // valid for product with no ready, and product holds until the next done.

  mul_state_t           state, state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic                 load, step, finish;
  logic [2*WIDTH-1:0]   acc_nxt;
  logic                 mplr_zero;

  shift_add_dp #(.WIDTH(WIDTH)) u_dp (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .step      (step),
    .a         (a),
    .b         (b),
    .acc_nxt   (acc_nxt),
    .mplr_zero (mplr_zero)
  );

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
`ifdef SEQ_MUL_EARLY_TERM_EN
        // No bits left to add: acc_nxt equals acc, so finish without stepping.
        if (mplr_zero) begin
          finish    = 1'b1;
          state_nxt = DONE;
        end else begin
          step = 1'b1;
          if (cnt == CNT_LAST) begin
            finish    = 1'b1;
            state_nxt = DONE;
          end
        end
`else
        step = 1'b1;
        if (cnt == CNT_LAST) begin
          finish    = 1'b1;
          state_nxt = DONE;
        end
`endif
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      product <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        cnt <= '0;
      end else if (step) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (finish) begin
        product <= acc_nxt;
      end
    end
  end

  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign state_dbg = state;

endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Sequential shift-add unsigned multiplier. It replaces the single-cycle `op1*op2` product that feeds the comparator/result register stage. It sits between the button-loaded operand registers and the downstream comparator, and presents the 2×WIDTH product with a one-cycle `done` strobe. The strobe is the load qualifier for the downstream result register.

## Interface
- `WIDTH`, default 8: operand width in bits; product is 2×WIDTH.
- `clk`  input  1  single system clock; all state updates on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `start`  input  1  request; sampled only in IDLE.
- `a`  input  WIDTH  multiplicand, unsigned; captured on accepted start.
- `b`  input  WIDTH  multiplier, unsigned; captured on accepted start.
- `busy`  output  1  high while in RUN.
- `done`  output  1  one-cycle pulse; `product` valid and new.
- `product`  output  2×WIDTH  registered result; holds until next `done`.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE, `start`=1:
  - capture `mcand`={WIDTH zeros, a} (2×WIDTH) and `mplr`=b;
  - clear `acc` and `cnt`;
  - go to RUN.
- IDLE, `start`=0: stay; `a`/`b` not sampled.
- RUN, each cycle:
  - if `mplr[0]`: `acc` += `mcand`, modulo 2^(2×WIDTH); it cannot overflow;
  - `mcand` <<= 1; `mplr` >>= 1; `cnt`++;
  - when `cnt` reaches WIDTH-1 on this cycle (the WIDTH-th iteration), go to DONE.
- DONE, one cycle:
  - `product` <= final `acc` (loaded on entry edge);
  - `done`=1; then IDLE.
  - `start` in DONE is ignored and must be re-presented in IDLE.
- `a`/`b` changes after capture have no effect on the running operation.
- `cnt` width: clog2(WIDTH)+1 bits.
- Reset at any point, including mid-RUN or in DONE:
  - next state IDLE;
  - `busy`=0, `done`=0, `product`=0, internal registers cleared;
  - the in-flight result is discarded.

## Timing
- Reset values: `busy`=0, `done`=0, `product`=0.
- `start` high in cycle 0 (IDLE):
  - `busy`=1 in cycles 1..WIDTH;
  - `done`=1 and new `product` in cycle WIDTH+1, with `busy`=0 in that cycle;
  - IDLE again in cycle WIDTH+2.
- Latency: WIDTH+1 cycles (9 for WIDTH=8).
- Minimum start-to-start period: WIDTH+2 cycles.
- `busy` and `done` are never high together.
- `product` changes only on the edge that raises `done`, or on reset.

## Configuration
- `SEQ_MUL_EARLY_TERM_EN` defined:
  - in RUN, if remaining `mplr`==0 at the start of a cycle, go to DONE immediately, with no add that cycle;
  - `done` cycle = min(h+3, WIDTH+1), where h = index of highest set bit of b;
  - b=0 gives `done` in cycle 2.
- Undefined: fixed WIDTH+1 latency regardless of operands.
- Product value is identical in both builds.

## Structure
- Shared package `arith_pkg`:
  - state enum `mul_state_t` {IDLE, RUN, DONE};
  - default width constant `ARITH_WIDTH`=8.
- Optional sub-module `shift_add_dp`: holds the `acc`/`mcand`/`mplr` registers and the conditional add. The FSM and counter stay in `seq_multiplier`.

## Test plan
- Reset, then idle 5 cycles -> `busy`=0, `done`=0, `product`=0x0000 throughout.
- a=0xFF, b=0xFF, start in cycle 0 -> `busy` cycles 1–8; `done` cycle 9; `product`=0xFE01.
- a=0x0C, b=0x0A; then a=0x03, b=0x05 started in the DONE cycle and again in the first IDLE cycle:
  - first result: `product`=0x0078;
  - DONE-cycle start ignored;
  - IDLE-cycle start accepted, giving 0x000F after 9 cycles.
- a=0x12, b=0x34; change a/b to 0x00 during RUN -> `product`=0x03A8.
- Start a=0x55, b=0xAA; assert `rst` in cycle 4 -> all outputs 0 next cycle, no `done`; a subsequent start computes correctly.
- With `SEQ_MUL_EARLY_TERM_EN`:
  - a=0x37, b=0x00 -> `done` cycle 2, `product`=0x0000;
  - b=0x03, a=0x10 -> `done` cycle 4, `product`=0x0030;
  - b=0x80 -> `done` cycle 9.
